// File: rtl/uart_tx_if.sv
// Byte handoff channel into the serial transmitter: data/valid from upstream, ready back.
interface uart_tx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// Asynchronous serial transmitter: start bit, LSB-first data, optional parity, stop bit(s),
// with bit timing from an internal divide-by-CLKS_PER_BIT tick counter.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       RST,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic [TICK_W-1:0]    tick;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic                 ready_q;
  logic                 tick_last;

  assign tick_last   = (tick == TICK_W'(CLKS_PER_BIT - 1));
  assign bus.tx_ready = ready_q;

  // Frame sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      tick       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_valid && ready_q) begin
            state      <= START;
            shift      <= bus.tx_data;
            parity_bit <= (^bus.tx_data) ^ (PARITY_ODD != 0);
            tick       <= '0;
            tx         <= 1'b0;
            ready_q    <= 1'b0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (tick_last) begin
            state   <= DATA;
            tick    <= '0;
            bit_cnt <= '0;
            tx      <= shift[0];
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        DATA: begin
          if (tick_last) begin
            tick <= '0;
            if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        PARITY: begin
          if (tick_last) begin
            state   <= STOP;
            tick    <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        STOP: begin
          // The bit counter is reused here to count stop bits.
          if (tick_last) begin
            tick <= '0;
            if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
              state   <= IDLE;
              bit_cnt <= '0;
              ready_q <= 1'b1;
              busy    <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: several parameterisations side by side, each checked cycle by cycle
// against a frame model built from the start/data/parity/stop layout.
module tb_uart_tx;

  localparam int NDUT = 5;
  localparam int unsigned CPB [NDUT] = '{4, 4, 4, 4, 2};
  localparam int unsigned PE  [NDUT] = '{0, 1, 1, 1, 0};
  localparam int unsigned PO  [NDUT] = '{0, 0, 1, 0, 0};
  localparam int unsigned SB  [NDUT] = '{1, 1, 1, 2, 1};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      data_q [NDUT];
  logic [NDUT-1:0] valid_q;
  logic [NDUT-1:0] ready_w, tx_w, busy_w, done_w;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx_if #(.DATA_BITS(8)) bus ();
    assign bus.tx_data  = data_q[g];
    assign bus.tx_valid = valid_q[g];
    assign ready_w[g]   = bus.tx_ready;
    uart_tx #(
      .CLKS_PER_BIT(CPB[g]),
      .DATA_BITS   (8),
      .PARITY_EN   (PE[g]),
      .PARITY_ODD  (PO[g]),
      .STOP_BITS   (SB[g])
    ) dut (
      .clk    (clk),
      .RST    (rst),
      .bus    (bus),
      .tx     (tx_w[g]),
      .busy   (busy_w[g]),
      .tx_done(done_w[g])
    );
  end

  function automatic int frame_len(int idx);
    return (1 + 8 + int'(PE[idx]) + int'(SB[idx])) * int'(CPB[idx]);
  endfunction

  // Line level expected during cycle N+1+j of a frame accepted at edge N.
  function automatic logic exp_level(int idx, logic [7:0] d, int j);
    int b;
    b = j / int'(CPB[idx]);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (PE[idx] != 0 && b == 9) return (^d) ^ (PO[idx] != 0);
    return 1'b1;
  endfunction

  task automatic chk(string tag, int idx, int j, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut=%0d cyc=%0d observed=%b expected=%b", tag, idx, j, obs, exp);
    end
  endtask

  task automatic chk_idle(string tag, int idx, logic done_exp);
    chk({tag, "_tx"},    idx, -1, tx_w[idx],    1'b1);
    chk({tag, "_ready"}, idx, -1, ready_w[idx], 1'b1);
    chk({tag, "_busy"},  idx, -1, busy_w[idx],  1'b0);
    chk({tag, "_done"},  idx, -1, done_w[idx],  done_exp);
  endtask

  // Called at the sample point just after the accepting edge; checks nmax cycles of frame.
  task automatic check_body(int idx, logic [7:0] d, bit mid_change, int nmax);
    for (int j = 0; j < nmax; j++) begin
      if (j > 0) @(negedge clk);
      chk("tx",    idx, j, tx_w[idx],    exp_level(idx, d, j));
      chk("ready", idx, j, ready_w[idx], 1'b0);
      chk("busy",  idx, j, busy_w[idx],  1'b1);
      chk("done",  idx, j, done_w[idx],  1'b0);
      if (mid_change && j == frame_len(idx) / 2) data_q[idx] = 8'hFF;
    end
  endtask

  task automatic run_frame(int idx, logic [7:0] d, bit mid_change);
    data_q[idx]  = d;
    valid_q[idx] = 1'b1;
    @(negedge clk);
    valid_q[idx] = 1'b0;
    check_body(idx, d, mid_change, frame_len(idx));
    @(negedge clk);
    chk_idle("end", idx, 1'b1);
    @(negedge clk);
    chk("done_clear", idx, -1, done_w[idx], 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NDUT; i++) data_q[i] = 8'($urandom);
    valid_q = '1;
    rst     = 1'b1;

    // Reset held with tx_valid asserted: nothing may start.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) chk_idle("reset", i, 1'b0);
    end
    rst     = 1'b0;
    valid_q = '0;
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) chk_idle("post_reset", i, 1'b0);

    // 8N1 0xA5 with tx_data disturbed mid-frame.
    run_frame(0, 8'hA5, 1'b1);
    // Parity even / odd, then even with two stop bits.
    run_frame(1, 8'h07, 1'b0);
    run_frame(2, 8'h07, 1'b0);
    run_frame(3, 8'h07, 1'b0);
    // Minimum divisor.
    run_frame(4, 8'h81, 1'b0);

    // Random bytes on every configuration.
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < NDUT; i++) run_frame(i, 8'($urandom), 1'b1);

    // Back-to-back with tx_valid held: one idle cycle, then second acceptance.
    data_q[0]  = 8'h00;
    valid_q[0] = 1'b1;
    @(negedge clk);
    data_q[0] = 8'hFF;
    check_body(0, 8'h00, 1'b0, frame_len(0));
    @(negedge clk);
    chk_idle("b2b_gap", 0, 1'b1);
    @(negedge clk);
    valid_q[0] = 1'b0;
    check_body(0, 8'hFF, 1'b0, frame_len(0));
    @(negedge clk);
    chk_idle("b2b_end", 0, 1'b1);
    @(negedge clk);

    // Reset during data bit 3 of 0x55, then a clean 0x3C frame.
    data_q[0]  = 8'h55;
    valid_q[0] = 1'b1;
    @(negedge clk);
    valid_q[0] = 1'b0;
    check_body(0, 8'h55, 1'b0, 18);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("abort", 0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("abort_after", 0, 1'b0);
    run_frame(0, 8'h3C, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
